padding_scan_ctrl: RTL and testbench

Sequencer that sits directly upstream of zero_padding in the conv feature-map path.
- Walks a padded feature map of (IMG_H+2*PAD) x (IMG_W+2*PAD) positions in raster order.
- Issues feature-memory reads for interior positions only.
- Drives en_padding, one cycle later and aligned with the memory read data, so zero_padding substitutes zero on border positions.
- Its outputs feed the zero_padding / line-buffer / convolution window logic.

---
 rtl/padding_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_padding_scan_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/padding_scan_ctrl.sv
// padding_scan_ctrl: raster-order walker over a zero-padded feature map.
// It issues feature-memory reads only for interior positions, and presents each
// padded position one cycle later, aligned with the memory read data. The
// en_padding output tells zero_padding which presented pixels are border.
module padding_scan_ctrl #(
    parameter int unsigned IMG_W      = 4,
    parameter int unsigned IMG_H      = 4,
    parameter int unsigned PAD        = 1,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stall,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  out_valid,
    output logic                  en_padding,
    output logic [CNT_WIDTH-1:0]  out_row,
    output logic [CNT_WIDTH-1:0]  out_col,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned W_P = IMG_W + 2 * PAD;
    localparam int unsigned H_P = IMG_H + 2 * PAD;

    localparam logic [CNT_WIDTH-1:0] LAST_COL = CNT_WIDTH'(W_P - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_ROW = CNT_WIDTH'(H_P - 1);
    localparam logic [CNT_WIDTH-1:0] PAD_C    = CNT_WIDTH'(PAD);
    localparam logic [CNT_WIDTH-1:0] IMG_W_C  = CNT_WIDTH'(IMG_W);
    localparam logic [CNT_WIDTH-1:0] IMG_H_C  = CNT_WIDTH'(IMG_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_all_issued;
    logic [CNT_WIDTH-1:0]  r_row;
    logic [CNT_WIDTH-1:0]  r_col;
    logic [ADDR_WIDTH-1:0] r_addr_cnt;

    // Issue stage (what goes to memory this cycle).
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_iss_valid;
    logic                  r_iss_border;
    logic                  r_iss_last;
    logic [CNT_WIDTH-1:0]  r_iss_row;
    logic [CNT_WIDTH-1:0]  r_iss_col;

    // Present stage (aligned with the memory read data).
    logic                  r_out_valid;
    logic                  r_en_padding;
    logic                  r_out_last;
    logic [CNT_WIDTH-1:0]  r_out_row;
    logic [CNT_WIDTH-1:0]  r_out_col;
    logic                  r_busy;
    logic                  r_done;

    logic [CNT_WIDTH-1:0]  w_row_off;
    logic [CNT_WIDTH-1:0]  w_col_off;
    logic                  w_border;
    logic                  w_at_last_col;
    logic                  w_at_last;
    logic                  w_issue;

    // Border test by offset: r-PAD wraps to a large value above the border,
    // so one unsigned compare per axis covers both sides.
    always_comb begin
        w_row_off     = r_row - PAD_C;
        w_col_off     = r_col - PAD_C;
        w_border      = !((w_row_off < IMG_H_C) && (w_col_off < IMG_W_C));
        w_at_last_col = (r_col == LAST_COL);
        w_at_last     = w_at_last_col && (r_row == LAST_ROW);
        w_issue       = ((r_state == S_IDLE) && start) ||
                        ((r_state == S_SCAN) && !r_all_issued && !stall);
    end

    // Control FSM, position/address counters, issue and present pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_all_issued <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
            r_addr_cnt   <= '0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_iss_valid  <= 1'b0;
            r_iss_border <= 1'b0;
            r_iss_last   <= 1'b0;
            r_iss_row    <= '0;
            r_iss_col    <= '0;
            r_out_valid  <= 1'b0;
            r_en_padding <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SCAN;
                        r_busy  <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (r_all_issued) begin
                        r_state      <= S_DRAIN;
                        r_all_issued <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            r_iss_valid  <= w_issue;
            r_iss_border <= w_issue && w_border;
            r_iss_last   <= w_issue && w_at_last;
            r_rd_en      <= w_issue && !w_border;

            if (w_issue) begin
                r_iss_row <= r_row;
                r_iss_col <= r_col;
                if (!w_border) begin
                    r_rd_addr  <= r_addr_cnt;
                    r_addr_cnt <= r_addr_cnt + ADDR_WIDTH'(1);
                end
                if (w_at_last) begin
                    r_row        <= '0;
                    r_col        <= '0;
                    r_addr_cnt   <= '0;
                    r_all_issued <= 1'b1;
                end else if (w_at_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + CNT_WIDTH'(1);
                end else begin
                    r_col <= r_col + CNT_WIDTH'(1);
                end
            end

            r_out_valid  <= r_iss_valid;
            r_en_padding <= r_iss_border;
            r_out_last   <= r_iss_last;
            r_out_row    <= r_iss_row;
            r_out_col    <= r_iss_col;
        end
    end

    assign rd_en      = r_rd_en;
    assign rd_addr    = r_rd_addr;
    assign out_valid  = r_out_valid;
    assign en_padding = r_en_padding;
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;
    assign out_last   = r_out_last;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_padding_scan_ctrl.sv
// Bench for padding_scan_ctrl: two instances (4x4 PAD=1 and 3x2 PAD=0) checked
// every cycle against a position-index reference model, plus literal checks.
module tb_padding_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start_a, stall_a, start_b, stall_b;

    logic       rd_en_a, out_valid_a, en_padding_a, out_last_a, busy_a, done_a;
    logic [9:0] rd_addr_a;
    logic [7:0] out_row_a, out_col_a;
    logic       rd_en_b, out_valid_b, en_padding_b, out_last_b, busy_b, done_b;
    logic [9:0] rd_addr_b;
    logic [7:0] out_row_b, out_col_b;

    always #5 clk = ~clk;

    padding_scan_ctrl #(.IMG_W(4), .IMG_H(4), .PAD(1), .ADDR_WIDTH(10), .CNT_WIDTH(8)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stall(stall_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .out_valid(out_valid_a),
        .en_padding(en_padding_a), .out_row(out_row_a), .out_col(out_col_a),
        .out_last(out_last_a), .busy(busy_a), .done(done_a));

    padding_scan_ctrl #(.IMG_W(3), .IMG_H(2), .PAD(0), .ADDR_WIDTH(10), .CNT_WIDTH(8)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stall(stall_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .out_valid(out_valid_b),
        .en_padding(en_padding_b), .out_row(out_row_b), .out_col(out_col_b),
        .out_last(out_last_b), .busy(busy_b), .done(done_b));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model (position index n over W_P*H_P) -----------
    int mW[2] = '{4, 3};
    int mH[2] = '{4, 2};
    int mP[2] = '{1, 0};
    int m_phase[2];   // 0 idle, 1 scan, 2 drain, 3 done
    int m_n[2];       // index of next position to issue
    bit m_init[2];
    int i_v[2], i_pad[2], i_row[2], i_col[2], i_last[2];
    int e_rd_en[2], e_rd_addr[2], e_ov[2], e_pad[2], e_row[2], e_col[2], e_last[2];
    int e_busy[2], e_done[2];

    task automatic model_step(input int i, input logic rst, input logic st, input logic sl);
        int wp, hp, nn, r, c, border;
        bit issue;
        wp = mW[i] + 2 * mP[i];
        hp = mH[i] + 2 * mP[i];
        nn = wp * hp;
        if (!rst) begin
            m_init[i] = 1'b1;
            m_phase[i] = 0; m_n[i] = 0;
            i_v[i] = 0; i_pad[i] = 0; i_row[i] = 0; i_col[i] = 0; i_last[i] = 0;
            e_rd_en[i] = 0; e_rd_addr[i] = 0; e_ov[i] = 0; e_pad[i] = 0;
            e_row[i] = 0; e_col[i] = 0; e_last[i] = 0; e_busy[i] = 0; e_done[i] = 0;
            return;
        end
        issue = 1'b0;
        case (m_phase[i])
            0: if (st) begin issue = 1'b1; m_phase[i] = 1; end
            1: if (m_n[i] == nn) m_phase[i] = 2; else if (!sl) issue = 1'b1;
            2: m_phase[i] = 3;
            default: begin m_phase[i] = 0; m_n[i] = 0; end
        endcase
        e_ov[i] = i_v[i]; e_pad[i] = i_pad[i]; e_row[i] = i_row[i];
        e_col[i] = i_col[i]; e_last[i] = i_last[i];
        i_v[i] = issue; i_pad[i] = 0; i_last[i] = 0; e_rd_en[i] = 0;
        if (issue) begin
            r = m_n[i] / wp;
            c = m_n[i] % wp;
            border = (r < mP[i]) || (r >= mH[i] + mP[i]) || (c < mP[i]) || (c >= mW[i] + mP[i]);
            i_pad[i] = border; i_row[i] = r; i_col[i] = c;
            i_last[i] = (m_n[i] == nn - 1);
            if (!border) begin
                e_rd_en[i] = 1;
                e_rd_addr[i] = (r - mP[i]) * mW[i] + (c - mP[i]);
            end
            m_n[i]++;
        end
        e_busy[i] = (m_phase[i] != 0);
        e_done[i] = (m_phase[i] == 3);
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step(0, rst_n, start_a, stall_a);
        model_step(1, rst_n, start_b, stall_b);
    end

    // ---------------- per-cycle compare and statistics ---------------------------
    int cnt_ov[2], cnt_rd[2], cnt_pad[2], cnt_done[2], cnt_busy[2];
    int first_v[2], last_v[2], done_cyc[2], busy_first[2], busy_last[2];
    int first_r[2], first_c[2], last_r[2], last_c[2];
    int pad_at[2][8][8];
    int addr_at[2][8][8];
    int addr_log[$];
    logic [9:0] prev_addr[2];

    task automatic clear_stats(input int i);
        cnt_ov[i] = 0; cnt_rd[i] = 0; cnt_pad[i] = 0; cnt_done[i] = 0; cnt_busy[i] = 0;
        first_v[i] = -1; last_v[i] = -1; done_cyc[i] = -1; busy_first[i] = -1; busy_last[i] = -1;
        first_r[i] = -1; first_c[i] = -1; last_r[i] = -1; last_c[i] = -1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                pad_at[i][r][c] = -1;
                addr_at[i][r][c] = -1;
            end
        if (i == 1) addr_log.delete();
    endtask

    task automatic compare(input int i, input logic rde, input logic [9:0] addr, input logic ov,
                           input logic pad, input logic [7:0] row, input logic [7:0] col,
                           input logic last, input logic bsy, input logic dn);
        string s;
        s = (i == 0) ? "a" : "b";
        chk({s, "_rd_en"},      32'(rde),  32'(e_rd_en[i]));
        chk({s, "_rd_addr"},    32'(addr), 32'(e_rd_addr[i]));
        chk({s, "_out_valid"},  32'(ov),   32'(e_ov[i]));
        chk({s, "_en_padding"}, 32'(pad),  32'(e_pad[i]));
        chk({s, "_out_last"},   32'(last), 32'(e_last[i]));
        chk({s, "_busy"},       32'(bsy),  32'(e_busy[i]));
        chk({s, "_done"},       32'(dn),   32'(e_done[i]));
        if (e_ov[i] != 0) begin
            chk({s, "_out_row"}, 32'(row), 32'(e_row[i]));
            chk({s, "_out_col"}, 32'(col), 32'(e_col[i]));
        end
        if (ov === 1'b1 && row < 8 && col < 8) begin
            cnt_ov[i]++;
            if (first_v[i] < 0) begin first_v[i] = cyc; first_r[i] = row; first_c[i] = col; end
            last_v[i] = cyc;
            pad_at[i][row][col] = pad;
            if (pad === 1'b0) begin
                addr_at[i][row][col] = prev_addr[i];
                if (i == 1) addr_log.push_back(int'(prev_addr[i]));
            end
            if (pad === 1'b1) cnt_pad[i]++;
            if (last === 1'b1) begin last_r[i] = row; last_c[i] = col; end
        end
        if (rde === 1'b1) cnt_rd[i]++;
        if (dn === 1'b1) begin cnt_done[i]++; done_cyc[i] = cyc; end
        if (bsy === 1'b1) begin
            cnt_busy[i]++;
            if (busy_first[i] < 0) busy_first[i] = cyc;
            busy_last[i] = cyc;
        end
        prev_addr[i] = addr;
    endtask

    always @(negedge clk) begin
        if (m_init[0]) compare(0, rd_en_a, rd_addr_a, out_valid_a, en_padding_a, out_row_a,
                               out_col_a, out_last_a, busy_a, done_a);
        if (m_init[1]) compare(1, rd_en_b, rd_addr_b, out_valid_b, en_padding_b, out_row_b,
                               out_col_b, out_last_b, busy_b, done_b);
    end

    // ---------------- stimulus helpers ------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_until_done(input int i, input int bound);
        int k = 0;
        while (!(cnt_done[i] > 0 && m_phase[i] == 0) && k < bound) begin
            step();
            k++;
        end
        chk($sformatf("done_wait_%0d", i), 32'(k < bound), 32'd1);
        step();
        step();
    endtask

    task automatic wait_pos(input int i, input int target, input int bound);
        int k = 0;
        while (m_n[i] != target && k < bound) begin
            step();
            k++;
        end
        chk($sformatf("pos_wait_%0d_%0d", i, target), 32'(k < bound), 32'd1);
    endtask

    task automatic pulse_start_a(output int s0);
        start_a = 1'b1;
        s0 = cyc;
        step();
        start_a = 1'b0;
    endtask

    int s0;

    initial begin
        rst_n = 1'b0; start_a = 1'b0; stall_a = 1'b0; start_b = 1'b0; stall_b = 1'b0;
        clear_stats(0);
        clear_stats(1);
        step();
        step();
        chk("reset_outputs_a", {rd_en_a, rd_addr_a, out_valid_a, en_padding_a, out_row_a,
                                out_col_a, out_last_a, busy_a, done_a}, 32'd0);
        rst_n = 1'b1;

        // Idle with stall toggling: nothing may start.
        clear_stats(0);
        for (int k = 0; k < 12; k++) begin
            stall_a = k[0];
            stall_b = ~k[0];
            step();
        end
        stall_a = 1'b0; stall_b = 1'b0;
        chk("idle_activity", 32'(cnt_ov[0] + cnt_rd[0] + cnt_busy[0]), 32'd0);

        // Plain scan, 4x4 PAD=1.
        clear_stats(0);
        pulse_start_a(s0);
        run_until_done(0, 200);
        chk("t1_valid_count", 32'(cnt_ov[0]), 32'd36);
        chk("t1_rd_count", 32'(cnt_rd[0]), 32'd16);
        chk("t1_pad_0_0", 32'(pad_at[0][0][0]), 32'd1);
        chk("t1_pad_0_5", 32'(pad_at[0][0][5]), 32'd1);
        chk("t1_addr_1_1", 32'(addr_at[0][1][1]), 32'd0);
        chk("t1_addr_4_4", 32'(addr_at[0][4][4]), 32'd15);
        chk("t1_last_pos", 32'(last_r[0] * 10 + last_c[0]), 32'd55);
        chk("t1_done_cycle", 32'(done_cyc[0] - s0), 32'd38);
        chk("t1_done_count", 32'(cnt_done[0]), 32'd1);
        chk("t1_busy_first", 32'(busy_first[0] - s0), 32'd1);
        chk("t1_busy_last", 32'(busy_last[0] - s0), 32'd38);

        // Stall three cycles at (2,3).
        clear_stats(0);
        pulse_start_a(s0);
        wait_pos(0, 15, 100);
        stall_a = 1'b1;
        step(); step(); step();
        stall_a = 1'b0;
        run_until_done(0, 200);
        chk("t2_valid_count", 32'(cnt_ov[0]), 32'd36);
        chk("t2_rd_count", 32'(cnt_rd[0]), 32'd16);
        chk("t2_bubbles", 32'(last_v[0] - first_v[0] + 1 - cnt_ov[0]), 32'd3);
        chk("t2_addr_2_3", 32'(addr_at[0][2][3]), 32'd6);

        // Start re-pulsed mid-scan at (3,2) is ignored.
        clear_stats(0);
        pulse_start_a(s0);
        wait_pos(0, 20, 100);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        run_until_done(0, 200);
        for (int k = 0; k < 5; k++) step();
        chk("t3_done_count", 32'(cnt_done[0]), 32'd1);
        chk("t3_valid_count", 32'(cnt_ov[0]), 32'd36);

        // Reset mid-scan at (2,2), then rescan.
        clear_stats(0);
        pulse_start_a(s0);
        wait_pos(0, 14, 100);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t4_outputs_zero", {rd_en_a, rd_addr_a, out_valid_a, en_padding_a, out_row_a,
                                out_col_a, out_last_a, busy_a, done_a}, 32'd0);
        clear_stats(0);
        for (int k = 0; k < 5; k++) step();
        chk("t4_no_done", 32'(cnt_done[0] + cnt_ov[0]), 32'd0);
        pulse_start_a(s0);
        run_until_done(0, 200);
        chk("t4_first_pos", 32'(first_r[0] * 10 + first_c[0]), 32'd0);
        chk("t4_addr_1_1", 32'(addr_at[0][1][1]), 32'd0);
        chk("t4_valid_count", 32'(cnt_ov[0]), 32'd36);

        // PAD=0, 3x2.
        clear_stats(1);
        start_b = 1'b1;
        s0 = cyc;
        step();
        start_b = 1'b0;
        run_until_done(1, 100);
        chk("t5_valid_count", 32'(cnt_ov[1]), 32'd6);
        chk("t5_pad_count", 32'(cnt_pad[1]), 32'd0);
        chk("t5_rd_count", 32'(cnt_rd[1]), 32'd6);
        chk("t5_done_cycle", 32'(done_cyc[1] - s0), 32'd8);
        chk("t5_addr_len", 32'(addr_log.size()), 32'd6);
        for (int k = 0; k < addr_log.size(); k++)
            chk($sformatf("t5_addr_%0d", k), 32'(addr_log[k]), 32'(k));

        // Random start/stall/reset traffic on both instances.
        for (int k = 0; k < 2500; k++) begin
            start_a = ($urandom_range(0, 29) == 0);
            stall_a = ($urandom_range(0, 3) == 0);
            start_b = ($urandom_range(0, 19) == 0);
            stall_b = ($urandom_range(0, 2) == 0);
            rst_n   = ($urandom_range(0, 399) != 0);
            step();
        end
        rst_n = 1'b1; start_a = 1'b0; stall_a = 1'b0; start_b = 1'b0; stall_b = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
